// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: loads a 5-bit pattern, scans the message for in-byte and byte-crossing matches, and writes three counts back to memory.
module pattern_scan_ctrl #(
  parameter int MSG_BASE = 0,
  parameter int MSG_LEN  = 32,
  parameter int PAT_ADDR = 32,
  parameter int RES_ADDR = 33,
  parameter int AW       = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LD   = 3'd1;
  localparam logic [2:0] S_SCAN = 3'd2;
  localparam logic [2:0] S_WR0  = 3'd3;
  localparam logic [2:0] S_WR1  = 3'd4;
  localparam logic [2:0] S_WR2  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;
  logic [2:0]    r_state;
  logic [4:0]    r_pat;
  logic [7:0]    r_prev;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_ctb;
  logic [7:0]    r_cto;
  logic [7:0]    r_cts;
  logic [2:0]    w_w;
  logic [2:0]    w_x;
  logic [11:0]   w_cross;
  always_comb begin
    w_w = '0;
    w_x = '0;
    w_cross = {r_prev[3:0], mem_rd_data};
    for (int k = 0; k < 4; k++) begin
      w_w = w_w + 3'(mem_rd_data[k +: 5] == r_pat);
      w_x = w_x + 3'(w_cross[k + 4 +: 5] == r_pat);
    end
    w_x = (r_idx == '0) ? 3'd0 : w_x;
  end
  assign done        = r_state == S_DONE;
  assign busy        = r_state inside {S_LD, S_SCAN, S_WR0, S_WR1, S_WR2};
  assign mem_wr_en   = r_state inside {S_WR0, S_WR1, S_WR2};
  assign mem_wr_data = (r_state == S_WR0) ? r_ctb :
                       (r_state == S_WR1) ? r_cto :
                       (r_state == S_WR2) ? r_cts : 8'd0;
  assign mem_addr    = (r_state == S_LD)   ? AW'(PAT_ADDR) :
                       (r_state == S_SCAN) ? AW'(MSG_BASE) + r_idx :
                       (r_state == S_WR0)  ? AW'(RES_ADDR) :
                       (r_state == S_WR1)  ? AW'(RES_ADDR + 1) :
                       (r_state == S_WR2)  ? AW'(RES_ADDR + 2) : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_prev  <= '0;
      r_idx   <= '0;
      r_ctb   <= '0;
      r_cto   <= '0;
      r_cts   <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= start ? S_LD : S_IDLE;
        S_LD: begin
          r_pat   <= mem_rd_data[7:3];
          r_prev  <= '0;
          r_idx   <= '0;
          r_ctb   <= '0;
          r_cto   <= '0;
          r_cts   <= '0;
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          r_ctb   <= r_ctb + 8'(w_w);
          r_cto   <= r_cto + 8'(w_w != 3'd0);
          r_cts   <= r_cts + 8'(w_w) + 8'(w_x);
          r_prev  <= mem_rd_data;
          r_idx   <= r_idx + 1'b1;
          r_state <= (r_idx == AW'(MSG_LEN - 1)) ? S_WR0 : S_SCAN;
        end
        S_WR0:   r_state <= S_WR1;
        S_WR1:   r_state <= S_WR2;
        S_WR2:   r_state <= S_DONE;
        S_DONE:  r_state <= start ? S_LD : S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
